// File: rtl/lc_pkg.sv
// Shared types and constants for the LC line responder and its backing store.
package lc_pkg;

  localparam int unsigned LC_LINE_BYTES  = 64;
  localparam int unsigned LC_LINE_BITS   = 512;
  localparam int unsigned LC_OFFSET_BITS = 6;

  typedef logic [LC_LINE_BITS-1:0] lc_line_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } lc_resp_state_t;

endpackage

// File: rtl/lc_line_mem.sv
// Line-granular backing store: two prioritized synchronous write ports
// (L1 over init) and one combinational read port.
module lc_line_mem #(
  parameter int unsigned LINE_BITS = 512,
  parameter int unsigned MEM_LINES = 64,
  localparam int unsigned IDX_W    = $clog2(MEM_LINES)
) (
  input  logic                 clk_i,
  input  logic                 l1_we_i,
  input  logic [IDX_W-1:0]     l1_idx_i,
  input  logic [LINE_BITS-1:0] l1_data_i,
  input  logic                 init_we_i,
  input  logic [IDX_W-1:0]     init_idx_i,
  input  logic [LINE_BITS-1:0] init_data_i,
  input  logic [IDX_W-1:0]     rd_idx_i,
  output logic [LINE_BITS-1:0] rd_data_o
);

  logic [LINE_BITS-1:0] mem_q [MEM_LINES];
  logic                 init_blocked;

  assign init_blocked = l1_we_i && (l1_idx_i == init_idx_i);

  // No reset: contents survive rst so preloaded programs stay resident.
  always_ff @(posedge clk_i) begin
    if (init_we_i && !init_blocked) begin
      mem_q[init_idx_i] <= init_data_i;
    end
    if (l1_we_i) begin
      mem_q[l1_idx_i] <= l1_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/lc_line_responder.sv
// LC end of the L1<->LC line-fill interface: accepts reads/write-backs and
// returns fill lines a fixed LATENCY cycles after acceptance.
module lc_line_responder
  import lc_pkg::*;
#(
  parameter int unsigned LINE_BYTES = LC_LINE_BYTES,
  parameter int unsigned MEM_LINES  = 64,
  parameter int unsigned LATENCY    = 4
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    l1_valid_in,
  output logic                    l1_ready_out,
  input  logic [63:0]             l1_addr_in,
  input  logic                    l1_we_in,
  input  logic [8*LINE_BYTES-1:0] l1_value_in,
  output logic                    lc_valid_out,
  input  logic                    lc_ready_in,
  output logic [63:0]             lc_addr_out,
  output logic [8*LINE_BYTES-1:0] lc_value_out,
  input  logic                    init_we_in,
  input  logic [63:0]             init_addr_in,
  input  logic [8*LINE_BYTES-1:0] init_value_in,
  output logic                    busy_out
);

  localparam int unsigned LINE_BITS = 8 * LINE_BYTES;
  localparam int unsigned OFF_W     = $clog2(LINE_BYTES);
  localparam int unsigned IDX_W     = $clog2(MEM_LINES);
  localparam logic [7:0]  CNT_INIT  = 8'(LATENCY - 1);

  lc_resp_state_t       state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [63:0]          addr_q, addr_d;
  logic [LINE_BITS-1:0] value_q, value_d;
  logic                 valid_q, valid_d;
  logic [LINE_BITS-1:0] rd_data;
  logic                 req_accept;
  logic                 l1_wr;
  logic                 unused_init_addr;

  assign req_accept = l1_valid_in && (state_q == IDLE);
  assign l1_wr      = req_accept && l1_we_in;

  // Offset and aliasing high bits of the preload address are deliberately dropped.
  assign unused_init_addr = ^{init_addr_in[63:OFF_W+IDX_W], init_addr_in[OFF_W-1:0]};

  lc_line_mem #(
    .LINE_BITS (LINE_BITS),
    .MEM_LINES (MEM_LINES)
  ) u_mem (
    .clk_i       (clk_in),
    .l1_we_i     (l1_wr),
    .l1_idx_i    (l1_addr_in[OFF_W +: IDX_W]),
    .l1_data_i   (l1_value_in),
    .init_we_i   (init_we_in),
    .init_idx_i  (init_addr_in[OFF_W +: IDX_W]),
    .init_data_i (init_value_in),
    .rd_idx_i    (idx_q),
    .rd_data_o   (rd_data)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      value_q <= value_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    value_d = value_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        if (req_accept && !l1_we_in) begin
          addr_d  = {l1_addr_in[63:OFF_W], {OFF_W{1'b0}}};
          idx_d   = l1_addr_in[OFF_W +: IDX_W];
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Memory is sampled at the launch edge so earlier writes are visible.
        if (cnt_q == '0) begin
          value_d = rd_data;
          valid_d = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RESP: begin
        if (lc_ready_in) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign l1_ready_out = (state_q == IDLE);
  assign busy_out     = (state_q != IDLE);
  assign lc_valid_out = valid_q;
  assign lc_addr_out  = addr_q;
  assign lc_value_out = value_q;

endmodule

// File: tb/tb_lc_line_responder.sv
// Scoreboard bench for lc_line_responder: LATENCY=4 and LATENCY=1 instances.
module tb_lc_line_responder;
  import lc_pkg::*;

  localparam int unsigned LAT0 = 4;
  localparam int unsigned LAT1 = 1;

  typedef struct {
    int unsigned inst;
    logic [63:0] addr;
    lc_line_t    val;
    int unsigned t;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]                   l1_valid, l1_ready, l1_we, lc_valid, lc_ready, init_we, busy;
  logic [1:0][63:0]             l1_addr, lc_addr, init_addr;
  logic [1:0][LC_LINE_BITS-1:0] l1_value, lc_value, init_value;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  int unsigned ncyc  = 0;
  exp_t        sb[$];

  lc_line_responder #(.LINE_BYTES(64), .MEM_LINES(64), .LATENCY(LAT0)) u_dut4 (
    .clk_in(clk), .rst_in(rst),
    .l1_valid_in(l1_valid[0]), .l1_ready_out(l1_ready[0]), .l1_addr_in(l1_addr[0]),
    .l1_we_in(l1_we[0]), .l1_value_in(l1_value[0]),
    .lc_valid_out(lc_valid[0]), .lc_ready_in(lc_ready[0]), .lc_addr_out(lc_addr[0]),
    .lc_value_out(lc_value[0]),
    .init_we_in(init_we[0]), .init_addr_in(init_addr[0]), .init_value_in(init_value[0]),
    .busy_out(busy[0])
  );

  lc_line_responder #(.LINE_BYTES(64), .MEM_LINES(64), .LATENCY(LAT1)) u_dut1 (
    .clk_in(clk), .rst_in(rst),
    .l1_valid_in(l1_valid[1]), .l1_ready_out(l1_ready[1]), .l1_addr_in(l1_addr[1]),
    .l1_we_in(l1_we[1]), .l1_value_in(l1_value[1]),
    .lc_valid_out(lc_valid[1]), .lc_ready_in(lc_ready[1]), .lc_addr_out(lc_addr[1]),
    .lc_value_out(lc_value[1]),
    .init_we_in(init_we[1]), .init_addr_in(init_addr[1]), .init_value_in(init_value[1]),
    .busy_out(busy[1])
  );

  task automatic chk(input bit ok, input string name, input logic [511:0] act,
                     input logic [511:0] exp);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) ncyc <= ncyc + 1;

  // Monitor: pops an expectation on each rising fill and checks it every
  // cycle the fill is held, then checks the release after the handshake.
  logic [1:0] prev_v  = '0;
  logic [1:0] hs_pend = '0;
  logic [1:0] cur_ok  = '0;
  exp_t       cur [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      exp_t        e;
      bit          ok;
      int unsigned lat;
      e   = cur[d];
      ok  = cur_ok[d];
      lat = (d == 0) ? LAT0 : LAT1;
      if (hs_pend[d]) begin
        chk(lc_valid[d] == 1'b0, "valid_drop_after_hs", lc_valid[d], 0);
        chk(l1_ready[d] == 1'b1, "ready_after_hs", l1_ready[d], 1);
      end
      if (lc_valid[d] && !prev_v[d]) begin
        chk(sb.size() != 0, "unexpected_fill", lc_addr[d], 0);
        ok = (sb.size() != 0);
        if (ok) begin
          e = sb.pop_front();
          chk(e.inst == d, "fill_instance", d, e.inst);
          chk(ncyc == e.t + 1 + lat, "fill_latency", ncyc - e.t - 1, lat);
        end
      end
      if (lc_valid[d] && ok) begin
        chk(lc_addr[d] == e.addr, "fill_addr", lc_addr[d], e.addr);
        chk(lc_value[d] == e.val, "fill_value", lc_value[d], e.val);
      end
      cur[d]     <= e;
      cur_ok[d]  <= ok && lc_valid[d];
      hs_pend[d] <= lc_valid[d] && lc_ready[d];
      prev_v[d]  <= lc_valid[d];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_write(input int d, input logic [63:0] a, input lc_line_t v);
    init_we[d] = 1'b1; init_addr[d] = a; init_value[d] = v;
    tick();
    init_we[d] = 1'b0;
  endtask

  task automatic l1_write(input int d, input logic [63:0] a, input lc_line_t v);
    l1_valid[d] = 1'b1; l1_we[d] = 1'b1; l1_addr[d] = a; l1_value[d] = v;
    tick();
    l1_valid[d] = 1'b0; l1_we[d] = 1'b0;
  endtask

  task automatic l1_read(input int d, input logic [63:0] a, input lc_line_t v,
                         output int unsigned t);
    int unsigned k = 0;
    while (!l1_ready[d] && k < 100) begin tick(); k++; end
    chk(l1_ready[d] == 1'b1, "req_ready_timeout", l1_ready[d], 1);
    l1_valid[d] = 1'b1; l1_we[d] = 1'b0; l1_addr[d] = a;
    t = ncyc;
    sb.push_back('{inst: d, addr: a & ~64'h3F, val: v, t: ncyc});
    tick();
    l1_valid[d] = 1'b0;
  endtask

  task automatic wait_valid(input int d);
    int unsigned k = 0;
    while (!lc_valid[d] && k < 100) begin tick(); k++; end
    chk(lc_valid[d] == 1'b1, "fill_timeout", lc_valid[d], 1);
  endtask

  task automatic wait_idle(input int d);
    int unsigned k = 0;
    while ((!l1_ready[d] || lc_valid[d]) && k < 100) begin tick(); k++; end
    chk(l1_ready[d] && !lc_valid[d], "idle_timeout", {l1_ready[d], lc_valid[d]}, 2'b10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] words [10];
    lc_line_t    prog, p1, p2, pa5, p11, p22;
    int unsigned t_a, t_b;

    words = '{32'hD29FFFE0, 32'hD2800021, 32'h8B010002, 32'hCB010003, 32'h8A010004,
              32'hAA010005, 32'hCA010006, 32'hF9000002, 32'hD503201F, 32'hD4400000};
    prog = '0;
    for (int i = 0; i < 10; i++) prog[32*i +: 32] = words[i];
    p1  = {8{64'h0123_4567_89AB_CDEF}};
    p2  = {16{32'hDEAD_BEEF}};
    pa5 = {64{8'hA5}};
    p11 = {64{8'h11}};
    p22 = {64{8'h22}};

    l1_valid = '0; l1_we = '0; l1_addr = '0; l1_value = '0;
    lc_ready = '1; init_we = '0; init_addr = '0; init_value = '0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk(lc_valid[d] == 1'b0, "rst_valid", lc_valid[d], 0);
      chk(lc_addr[d] == 64'h0, "rst_addr", lc_addr[d], 0);
      chk(lc_value[d] == '0, "rst_value", lc_value[d], 0);
      chk(l1_ready[d] == 1'b1, "rst_ready", l1_ready[d], 1);
      chk(busy[d] == 1'b0, "rst_busy", busy[d], 0);
    end
    rst = 1'b0;
    tick();

    // Preloaded program fetched with ready held high.
    init_write(0, 64'h0, prog);
    init_write(0, 64'h40, p1);
    l1_read(0, 64'h0, prog, t_a);
    chk(busy[0] == 1'b1, "busy_wait", busy[0], 1);
    wait_idle(0);

    // Backpressure: fill held for six cycles with ready low.
    lc_ready[0] = 1'b0;
    l1_read(0, 64'h47, p1, t_a);
    wait_valid(0);
    repeat (6) tick();
    lc_ready[0] = 1'b1;
    tick();
    wait_idle(0);

    // Write-backs do not block; read right after a write sees it.
    l1_write(0, 64'h80, pa5);
    chk(l1_ready[0] == 1'b1, "ready_after_wr", l1_ready[0], 1);
    l1_read(0, 64'h80, pa5, t_a);
    wait_idle(0);
    l1_write(0, 64'h100, p1);
    l1_write(0, 64'h140, p2);
    l1_read(0, 64'h140, p2, t_a);
    wait_idle(0);
    l1_read(0, 64'h100, p1, t_a);
    wait_idle(0);

    // Same-cycle init and L1 write to one line: L1 wins.
    init_we[0] = 1'b1; init_addr[0] = 64'hC0; init_value[0] = p11;
    l1_valid[0] = 1'b1; l1_we[0] = 1'b1; l1_addr[0] = 64'hC0; l1_value[0] = p22;
    tick();
    init_we[0] = 1'b0; l1_valid[0] = 1'b0; l1_we[0] = 1'b0;
    l1_read(0, 64'hC0, p22, t_a);
    wait_idle(0);

    // Address aliasing past the backing-store depth.
    l1_read(0, 64'h1000, prog, t_a);
    wait_idle(0);

    // Init write during WAIT lands before launch and must be visible.
    l1_read(0, 64'h40, p2, t_a);
    init_write(0, 64'h40, p2);
    wait_idle(0);

    // Async reset during WAIT drops the pending read.
    l1_read(0, 64'h0, prog, t_a);
    tick();
    chk(busy[0] == 1'b1, "busy_before_rst", busy[0], 1);
    #2 rst = 1'b1;
    #1;
    chk(lc_valid[0] == 1'b0, "midrst_valid", lc_valid[0], 0);
    chk(busy[0] == 1'b0, "midrst_busy", busy[0], 0);
    chk(l1_ready[0] == 1'b1, "midrst_ready", l1_ready[0], 1);
    chk(lc_value[0] == '0, "midrst_value", lc_value[0], 0);
    sb.delete();
    #2 rst = 1'b0;
    repeat (10) tick();
    chk(lc_valid[0] == 1'b0 && busy[0] == 1'b0, "no_stale_fill", {lc_valid[0], busy[0]}, 0);

    // LATENCY=1 instance: back-to-back reads, one accepted every 3 cycles.
    init_write(1, 64'h0, prog);
    init_write(1, 64'h40, p1);
    l1_read(1, 64'h0, prog, t_a);
    l1_read(1, 64'h40, p1, t_b);
    chk(t_b - t_a == 3, "accept_spacing", t_b - t_a, 3);
    wait_idle(1);

    repeat (5) tick();
    chk(sb.size() == 0, "sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/lc_line_responder.md
Name: lc_line_responder

Overview:
- Synthesizable last-level-cache responder: the LC end of the L1<->LC line-fill interface.
- Accepts line requests from an L1 (read miss or write-back) and holds a line-granular backing store.
- Returns 512-bit fill lines after a fixed latency through a valid/ready response channel.
- Drives the l1i_lc_*/l1d_lc_* inputs of ozone in system benches, replacing hand-driven fill stimulus.

Parameters:
- LINE_BYTES, 64, cache line size in bytes; line width = 8*LINE_BYTES bits.
- MEM_LINES, 64, backing-store depth in lines (4 KB default); power of two.
- LATENCY, 4, cycles from request acceptance to lc_valid_out rising; legal range 1..255.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  reset, asynchronous, active-high.
- l1_valid_in  in  1  L1 request valid.
- l1_ready_out  out  1  responder can accept a request.
- l1_addr_in  in  64  request byte address; offset bits ignored.
- l1_we_in  in  1  1 = write-back of l1_value_in, 0 = line read.
- l1_value_in  in  512  write-back data.
- lc_valid_out  out  1  fill response valid.
- lc_ready_in  in  1  L1 accepts the fill.
- lc_addr_out  out  64  line-aligned address of the fill.
- lc_value_out  out  512  fill data.
- init_we_in  in  1  backdoor preload write enable.
- init_addr_in  in  64  preload byte address.
- init_value_in  in  512  preload line.
- busy_out  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, active-high):
  - State IDLE, counter 0.
  - lc_valid_out=0, lc_addr_out=0, lc_value_out=0, l1_ready_out=1, busy_out=0.
  - Memory contents are not cleared.
- Indexing: line index = addr[6 +: log2(MEM_LINES)]. Higher bits alias (wrap). lc_addr_out = l1_addr_in with bits[5:0] cleared.
- Handshake: a request is accepted at a posedge where l1_valid_in && l1_ready_out. l1_ready_out = (state==IDLE), combinational from state. Only one request is outstanding at a time.
- IDLE:
  - Read accepted -> capture aligned address and index; counter = LATENCY-1; go to WAIT.
  - Write accepted -> memory line written at that same edge; no response is issued; stay IDLE, so back-to-back writes run at 1/cycle.
- WAIT:
  - Counter decrements each cycle.
  - When the counter is 0, load lc_value_out from memory at the captured index and set lc_valid_out=1; go to RESP.
  - This gives lc_valid_out high exactly LATENCY cycles after the accepting edge.
- RESP:
  - lc_valid_out, lc_addr_out and lc_value_out are held stable until lc_ready_in=1 at a posedge.
  - Then lc_valid_out=0 and state goes to IDLE, so l1_ready_out is high the next cycle.
  - lc_value_out keeps its last value after the handshake.
- Read data is the memory content at the cycle the response launches. Any write (init or L1) committed before that edge is visible in the fill.
- Init port: writes on any posedge, in any state. If it targets the same index as an accepted L1 write in the same cycle, the L1 write wins.
- Reset mid-operation: any pending read is dropped, outputs return to their reset values, and no stale response is issued afterwards.
- lc_ready_in outside RESP is ignored.

Decomposition:
- Shared package lc_pkg:
  - LC_LINE_BYTES=64, LC_LINE_BITS=512, LC_OFFSET_BITS=6.
  - typedef lc_line_t (logic [511:0]).
  - enum lc_resp_state_t {IDLE, WAIT, RESP}.
- Sub-module lc_line_mem: MEM_LINES x 512 array.
  - Two prioritized synchronous write ports (L1 over init).
  - One combinational read port.
- The FSM and counter stay in lc_line_responder.

Test Plan:
- Preload line 0 via init with ten packed instructions (movz x0,#0xffff ... hlt); request read addr 0x0 at t0 with lc_ready_in=1 -> lc_valid_out high exactly 4 cycles after acceptance; lc_addr_out=0x0; lc_value_out equals preload; l1_ready_out returns 1 the next cycle.
- Read addr 0x47 with lc_ready_in held 0 for 6 cycles -> lc_addr_out=0x40; valid/addr/value stable all 6 cycles; released on the first ready edge.
- L1 write 0xA5..A5 to 0x80, then immediately read 0x80 -> l1_ready_out stays 1 after the write; fill returns 0xA5..A5.
- Same-cycle init write 0x11.. and L1 write 0x22.. to 0xC0, then read 0xC0 -> 0x22.. (L1 priority). Also read 0x1000 with MEM_LINES=64 -> aliases line 0.
- Assert rst_in asynchronously during WAIT -> lc_valid_out=0 and busy_out=0 immediately; no fill appears over the next 10 cycles.
- LATENCY=1 instance, back-to-back reads 0x0, 0x40 with lc_ready_in=1 -> each fill arrives 1 cycle after acceptance; one request accepted every 3 cycles.
